// File: rtl/instr_enc_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master issues requests and consumes words; the slave is the encoder.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_last, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_last, err
  );
endinterface

// File: rtl/instr_enc.sv
// Encodes mnemonic requests into RV32I words through a single output register.
// LI outside the 12-bit range expands to LUI (+ ADDI) using a second FSM state.
module instr_enc (
  input logic        clk,
  input logic        rst,
  instr_enc_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StLi2} state_e;

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpAnd   = 5'd2;
  localparam logic [4:0] OpOr    = 5'd3;
  localparam logic [4:0] OpXor   = 5'd4;
  localparam logic [4:0] OpSll   = 5'd5;
  localparam logic [4:0] OpSrl   = 5'd6;
  localparam logic [4:0] OpSra   = 5'd7;
  localparam logic [4:0] OpSlt   = 5'd8;
  localparam logic [4:0] OpSltu  = 5'd9;
  localparam logic [4:0] OpAddi  = 5'd10;
  localparam logic [4:0] OpAndi  = 5'd11;
  localparam logic [4:0] OpOri   = 5'd12;
  localparam logic [4:0] OpXori  = 5'd13;
  localparam logic [4:0] OpSlti  = 5'd14;
  localparam logic [4:0] OpSltiu = 5'd15;
  localparam logic [4:0] OpSlli  = 5'd16;
  localparam logic [4:0] OpSrli  = 5'd17;
  localparam logic [4:0] OpSrai  = 5'd18;
  localparam logic [4:0] OpLw    = 5'd19;
  localparam logic [4:0] OpSw    = 5'd20;
  localparam logic [4:0] OpBeq   = 5'd21;
  localparam logic [4:0] OpBne   = 5'd22;
  localparam logic [4:0] OpBlt   = 5'd23;
  localparam logic [4:0] OpBge   = 5'd24;
  localparam logic [4:0] OpBltu  = 5'd25;
  localparam logic [4:0] OpBgeu  = 5'd26;
  localparam logic [4:0] OpJal   = 5'd27;
  localparam logic [4:0] OpLui   = 5'd28;
  localparam logic [4:0] OpLi    = 5'd29;

  localparam logic [6:0] OpcR    = 7'b0110011;
  localparam logic [6:0] OpcImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad = 7'b0000011;
  localparam logic [6:0] OpcStor = 7'b0100011;
  localparam logic [6:0] OpcBr   = 7'b1100011;
  localparam logic [6:0] OpcJal  = 7'b1101111;
  localparam logic [6:0] OpcLui  = 7'b0110111;

  localparam logic [6:0] F7Base  = 7'b0000000;
  localparam logic [6:0] F7Alt   = 7'b0100000;

  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OpcR};
  endfunction

  function automatic logic [31:0] f_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] f_b(input logic [12:1] b, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], OpcBr};
  endfunction

  function automatic logic [31:0] f_j(input logic [20:1] j, input logic [4:0] rd);
    return {j[20], j[10:1], j[11], j[19:12], rd, OpcJal};
  endfunction

  state_e      r_state;
  state_e      w_state_d;
  logic        r_out_valid;
  logic        r_out_last;
  logic [31:0] r_out_instr;
  logic [31:0] r_pend;
  logic        r_err;

  logic        w_out_valid_d;
  logic        w_out_last_d;
  logic [31:0] w_out_instr_d;
  logic [31:0] w_pend_d;
  logic        w_err_d;

  logic        w_in_ready;
  logic        w_load_pend;
  logic        w_accept;

  logic [31:0] w_word;
  logic [31:0] w_pend;
  logic        w_last;
  logic        w_two;
  logic        w_bad;

  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;
  logic        w_br_ok;
  logic        w_jal_ok;
  logic        w_li_small;
  logic [19:0] w_li_hi;

  assign w_rd   = bus.in_rd;
  assign w_rs1  = bus.in_rs1;
  assign w_rs2  = bus.in_rs2;
  assign w_imm  = bus.in_imm;

  // Range checks: imm must be a sign extension of its low 13 / 21 / 12 bits.
  assign w_br_ok    = (w_imm[31:12] == {20{w_imm[12]}}) && !w_imm[0];
  assign w_jal_ok   = (w_imm[31:20] == {12{w_imm[20]}}) && !w_imm[0];
  assign w_li_small = (w_imm[31:11] == {21{w_imm[11]}});
  // (imm + 0x800)[31:12]: the carry into bit 12 is exactly imm[11].
  assign w_li_hi    = w_imm[31:12] + {19'b0, w_imm[11]};

  always_comb begin : decode
    w_word = '0;
    w_pend = '0;
    w_last = 1'b1;
    w_two  = 1'b0;
    w_bad  = 1'b0;
    case (bus.in_op)
      OpAdd:   w_word = f_r(F7Base, 3'b000, w_rd, w_rs1, w_rs2);
      OpSub:   w_word = f_r(F7Alt,  3'b000, w_rd, w_rs1, w_rs2);
      OpAnd:   w_word = f_r(F7Base, 3'b111, w_rd, w_rs1, w_rs2);
      OpOr:    w_word = f_r(F7Base, 3'b110, w_rd, w_rs1, w_rs2);
      OpXor:   w_word = f_r(F7Base, 3'b100, w_rd, w_rs1, w_rs2);
      OpSll:   w_word = f_r(F7Base, 3'b001, w_rd, w_rs1, w_rs2);
      OpSrl:   w_word = f_r(F7Base, 3'b101, w_rd, w_rs1, w_rs2);
      OpSra:   w_word = f_r(F7Alt,  3'b101, w_rd, w_rs1, w_rs2);
      OpSlt:   w_word = f_r(F7Base, 3'b010, w_rd, w_rs1, w_rs2);
      OpSltu:  w_word = f_r(F7Base, 3'b011, w_rd, w_rs1, w_rs2);
      OpAddi:  w_word = f_i(w_imm[11:0], w_rs1, 3'b000, w_rd, OpcImm);
      OpAndi:  w_word = f_i(w_imm[11:0], w_rs1, 3'b111, w_rd, OpcImm);
      OpOri:   w_word = f_i(w_imm[11:0], w_rs1, 3'b110, w_rd, OpcImm);
      OpXori:  w_word = f_i(w_imm[11:0], w_rs1, 3'b100, w_rd, OpcImm);
      OpSlti:  w_word = f_i(w_imm[11:0], w_rs1, 3'b010, w_rd, OpcImm);
      OpSltiu: w_word = f_i(w_imm[11:0], w_rs1, 3'b011, w_rd, OpcImm);
      OpSlli: begin
        w_word = f_i({F7Base, w_imm[4:0]}, w_rs1, 3'b001, w_rd, OpcImm);
        w_bad  = |w_imm[31:5];
      end
      OpSrli: begin
        w_word = f_i({F7Base, w_imm[4:0]}, w_rs1, 3'b101, w_rd, OpcImm);
        w_bad  = |w_imm[31:5];
      end
      OpSrai: begin
        w_word = f_i({F7Alt, w_imm[4:0]}, w_rs1, 3'b101, w_rd, OpcImm);
        w_bad  = |w_imm[31:5];
      end
      OpLw:    w_word = f_i(w_imm[11:0], w_rs1, 3'b010, w_rd, OpcLoad);
      OpSw:    w_word = {w_imm[11:5], w_rs2, w_rs1, 3'b010, w_imm[4:0], OpcStor};
      OpBeq: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b000);
        w_bad  = !w_br_ok;
      end
      OpBne: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b001);
        w_bad  = !w_br_ok;
      end
      OpBlt: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b100);
        w_bad  = !w_br_ok;
      end
      OpBge: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b101);
        w_bad  = !w_br_ok;
      end
      OpBltu: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b110);
        w_bad  = !w_br_ok;
      end
      OpBgeu: begin
        w_word = f_b(w_imm[12:1], w_rs2, w_rs1, 3'b111);
        w_bad  = !w_br_ok;
      end
      OpJal: begin
        w_word = f_j(w_imm[20:1], w_rd);
        w_bad  = !w_jal_ok;
      end
      OpLui:   w_word = {w_imm[31:12], w_rd, OpcLui};
      OpLi: begin
        if (w_li_small) begin
          w_word = f_i(w_imm[11:0], 5'd0, 3'b000, w_rd, OpcImm);
        end else begin
          w_word = {w_li_hi, w_rd, OpcLui};
          if (w_imm[11:0] != 12'd0) begin
            w_last = 1'b0;
            w_two  = 1'b1;
            w_pend = f_i(w_imm[11:0], w_rd, 3'b000, w_rd, OpcImm);
          end
        end
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin : next_state
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept && !w_bad && w_two) w_state_d = StLi2;
      StLi2:   if (bus.out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin : fsm_out
    w_in_ready  = (r_state == StIdle) && (!r_out_valid || bus.out_ready) && !rst;
    w_load_pend = (r_state == StLi2) && bus.out_ready;
  end

  // A rejected request loads nothing; the register only drains if consumed.
  always_comb begin : out_next
    w_out_valid_d = r_out_valid;
    w_out_last_d  = r_out_last;
    w_out_instr_d = r_out_instr;
    w_pend_d      = r_pend;
    w_err_d       = 1'b0;
    if (r_out_valid && bus.out_ready) w_out_valid_d = 1'b0;
    if (w_load_pend) begin
      w_out_valid_d = 1'b1;
      w_out_last_d  = 1'b1;
      w_out_instr_d = r_pend;
    end else if (w_accept) begin
      if (w_bad) begin
        w_err_d = 1'b1;
      end else begin
        w_out_valid_d = 1'b1;
        w_out_last_d  = w_last;
        w_out_instr_d = w_word;
        w_pend_d      = w_pend;
      end
    end
  end

  always_ff @(posedge clk) begin : out_reg
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_instr <= '0;
      r_pend      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_out_last  <= w_out_last_d;
      r_out_instr <= w_out_instr_d;
      r_pend      <= w_pend_d;
      r_err       <= w_err_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_instr = r_out_instr;
  assign bus.err       = r_err;

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request present.
REQ-004 SHALL have port in_ready, output, 1 bit: request accepted when in_valid & in_ready.
REQ-005 SHALL have port in_op, input, 5 bits, with this mnemonic code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 SLTI, 15 SLTIU, 16 SLLI, 17 SRLI, 18 SRAI, 19 LW, 20 SW, 21 BEQ, 22 BNE, 23 BLT, 24 BGE, 25 BLTU, 26 BGEU, 27 JAL, 28 LUI, 29 LI (pseudo); 30 and 31 are illegal.
REQ-006 SHALL have ports in_rd, in_rs1 and in_rs2, each input, 5 bits: register fields.
REQ-007 SHALL have port in_imm, input, 32 bits: signed immediate, byte offset for branch/JAL.
REQ-008 SHALL have port out_valid, output, 1 bit: out_instr holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: word consumed when out_valid & out_ready.
REQ-010 SHALL have port out_instr, output, 32 bits: RV32I instruction word.
REQ-011 SHALL have port out_last, output, 1 bit: out_instr is the final word of its request.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-013 SHALL encode standard RV32I formats:
- R (0110011): funct7 0100000 for SUB/SRA, 0000000 otherwise.
- I-ALU (0010011); shift-immediates use imm[4:0] as shamt, with funct7 0100000 for SRAI.
- LW (0000011), funct3 010; SW (0100011), funct3 010.
- B (1100011), funct3 000/001/100/101/110/111.
- JAL (1101111); LUI (0110111), using in_imm[31:12].
REQ-014 SHALL hold a single output register, so one word is emitted per request cycle.
REQ-015 SHALL accept a request only in state IDLE: in_ready = IDLE & (~out_valid | out_ready).
REQ-016 SHALL present an accepted non-pseudo request as out_valid=1, out_last=1 in the next cycle (latency 1).
REQ-017 SHALL sustain full throughput of one single-word request per cycle while out_ready=1.
REQ-018 SHALL keep out_instr, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL expand LI when in_imm lies within -2048..2047 to a single ADDI rd,x0,imm, with out_last=1.
REQ-020 SHALL expand any other LI as follows:
- lo = in_imm[11:0]; hi = (in_imm + 0x800)[31:12].
- Emit LUI rd,hi first.
- If lo != 0, LUI has out_last=0 and is followed by ADDI rd,rd,lo with out_last=1.
- If lo == 0, emit LUI alone with out_last=1.
REQ-021 SHALL use the state machine IDLE -> LI2 on acceptance of a two-word LI; LI2 -> IDLE when the first word is consumed, loading the ADDI into the output register in that same cycle; in_ready=0 in LI2.
REQ-022 SHALL reject the following conditions, and for each reject pulse err one cycle after acceptance, emit no word and leave out_valid unchanged:
- in_op 30 or 31.
- Shift-immediate with in_imm[31:5] != 0.
- Branch with in_imm odd or outside -4096..4094.
- JAL with in_imm odd or outside -1048576..1048574.
REQ-023 SHALL encode I/S immediates for non-shift ops from in_imm[11:0], silently truncated.
REQ-024 SHALL emit a word normally when rd=x0 (no special casing).

Reset
REQ-025 SHALL, with rst=1 at a clock edge, force the following: state IDLE, out_valid=0, out_last=0, out_instr=0, err=0.
REQ-026 SHALL discard any pending second LI word when rst is asserted mid-expansion; it is never emitted.
REQ-027 SHALL drive in_ready=0 during the reset cycle.

Verification
REQ-028 ADD rd=3 rs1=1 rs2=2 -> out_instr=0x002081B3, out_last=1, one cycle after acceptance.
REQ-029 LI rd=5 imm=0x12345678 -> 0x123452B7 (out_last=0), then 0x67828293 (out_last=1); in_ready=0 in between.
REQ-030 LI rd=1 imm=-1 -> single 0xFFF00093, out_last=1; LI rd=2 imm=0x00001000 -> single 0x00001137, out_last=1.
REQ-031 BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; BEQ imm=7 -> err pulse, no out_valid.
REQ-032 out_ready held 0 for 3 cycles with a word pending -> out_instr stable, in_ready=0; back-to-back ADDs with out_ready=1 -> one word per cycle.
REQ-033 rst asserted in LI2 -> next cycle out_valid=0, state IDLE, ADDI never appears; in_op=31 -> err=1 for exactly one cycle.
